// File: rtl/comparator_pkg.sv
// Shared constants and result-flag type for the registered magnitude comparator.
package comparator_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic greater;
        logic equal;
        logic lesser;
    } flags_t;

endpackage

// File: rtl/comparator_core.sv
// Combinational compare of a against b. One signed compare covers both
// signed and unsigned modes.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output flags_t           flags
);

    logic signed [WIDTH:0] a_ext_s;
    logic signed [WIDTH:0] b_ext_s;

    // Add one extra top bit. It copies the sign bit in signed mode and is zero otherwise.
    always_comb begin
        a_ext_s = $signed({is_signed & a[WIDTH-1], a});
        b_ext_s = $signed({is_signed & b[WIDTH-1], b});
        flags   = flags_t'(3'b000);
        if (a == b) begin
            flags.equal = 1'b1;
        end else if (a_ext_s > b_ext_s) begin
            flags.greater = 1'b1;
        end else begin
            flags.lesser = 1'b1;
        end
    end

endmodule

// File: rtl/comparator.sv
// Registered comparator. Operands qualified by in_valid produce flags one cycle
// later. The flags hold their values across idle cycles.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    output logic             greater,
    output logic             lesser,
    output logic             equal
);

    flags_t core_flags_s;
    flags_t flags_r;
    logic   out_valid_r;

    comparator_core #(.WIDTH(WIDTH)) u_core (
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .flags     (core_flags_s)
    );

    // Output stage. Reset wins over in_valid. The flags change only when a new pair is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            flags_r     <= flags_t'(3'b000);
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                flags_r <= core_flags_s;
            end else begin
                flags_r <= flags_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign greater   = flags_r.greater;
    assign lesser    = flags_r.lesser;
    assign equal     = flags_r.equal;

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: an integer-arithmetic reference model
// feeds a queue drained by an independent output monitor.
module tb_comparator;

    localparam int W = 4;

    typedef struct {
        logic [2:0] ref_f;   // {greater, equal, lesser}
        bit         chk;
        logic [2:0] exp_f;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_signed = 1'b0;
    logic         out_valid, greater, lesser, equal;

    bit           cur_chk = 1'b0;
    logic [2:0]   cur_exp = 3'b000;

    sb_t          sb_q[$];
    logic         exp_valid = 1'b0;
    logic [2:0]   held = 3'b000;
    int           checks = 0;
    int           errors = 0;
    bit           done = 1'b0;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] L = 3'b001;

    comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .greater   (greater),
        .lesser    (lesser),
        .equal     (equal)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_cmp(int av, int bv, bit s);
        int x = av;
        int y = bv;
        if (s && x >= (1 << (W - 1))) x = x - (1 << W);
        if (s && y >= (1 << (W - 1))) y = y - (1 << W);
        if (x > y) return G;
        if (x < y) return L;
        return E;
    endfunction

    task automatic check(string name, logic [2:0] act, logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b required %b", name, $time, act, req);
        end
    endtask

    task automatic drive(bit r, bit v, int av, int bv, bit s, bit chk, logic [2:0] ex);
        @(negedge clk);
        rst_n     = r;
        in_valid  = v;
        a         = W'(av);
        b         = W'(bv);
        is_signed = s;
        cur_chk   = chk;
        cur_exp   = ex;
    endtask

    // Reference model: at each edge, records what the next output cycle must show.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_valid = 1'b0;
                held      = 3'b000;
                sb_q.delete();
            end else if (in_valid) begin
                sb_t e;
                e.ref_f   = ref_cmp(int'(a), int'(b), is_signed);
                e.chk     = cur_chk;
                e.exp_f   = cur_exp;
                exp_valid = 1'b1;
                held      = e.ref_f;
                sb_q.push_back(e);
            end else begin
                exp_valid = 1'b0;
            end
        end
    end

    // Monitor: samples the outputs on the falling edge.
    initial begin
        logic [2:0] act;
        sb_t        e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            act = {greater, equal, lesser};
            check("out_valid", {2'b00, out_valid}, {2'b00, exp_valid});
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow at %0t: got result, required none", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("flags_vs_model", act, e.ref_f);
                    check("one_hot", 3'($countones(act)), 3'd1);
                    if (e.chk) check("flags_vs_directed", act, e.exp_f);
                end
            end else begin
                check("hold_flags", act, held);
            end
        end
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: bench did not finish, required completion");
            $fatal(1, "watchdog");
        end
    end

    initial begin
        // Reset held for a few cycles, including one cycle with valid operands presented.
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b1, 5, 3, 1'b0, 1'b0, 3'b000);
        drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 3'b000);

        // Single-pair cases in unsigned and signed mode
        drive(1'b1, 1'b1, 4'b0110, 4'b1010, 1'b0, 1'b1, L);
        drive(1'b1, 1'b1, 4'b0110, 4'b1010, 1'b1, 1'b1, G);

        // Back-to-back unsigned stream
        drive(1'b1, 1'b1, 4'b1110, 4'b1010, 1'b0, 1'b1, G);
        drive(1'b1, 1'b1, 4'b0100, 4'b0010, 1'b0, 1'b1, G);
        drive(1'b1, 1'b1, 4'b0110, 4'b0001, 1'b0, 1'b1, G);
        drive(1'b1, 1'b1, 4'b1101, 4'b1101, 1'b0, 1'b1, E);
        drive(1'b1, 1'b1, 4'b0111, 4'b1010, 1'b0, 1'b1, L);

        // Boundary operands
        drive(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, G);
        drive(1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, L);
        drive(1'b1, 1'b1, 4'b1000, 4'b0111, 1'b1, 1'b1, L);
        drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, E);
        drive(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, E);

        // Hold with in_valid low, then reset with in_valid high, then the first result after reset
        drive(1'b1, 1'b1, 4'b1000, 4'b0001, 1'b0, 1'b1, G);
        drive(1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 3'b000);
        drive(1'b1, 1'b0, 4'b0001, 4'b0010, 1'b1, 1'b0, 3'b000);
        drive(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0, 1'b0, 3'b000);
        drive(1'b1, 1'b1, 4'b0011, 4'b0101, 1'b0, 1'b1, L);
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 3'b000);

        // Exhaustive sweep: all operand pairs in both modes, at full throughput
        for (int s = 0; s < 2; s++)
            for (int x = 0; x < (1 << W); x++)
                for (int y = 0; y < (1 << W); y++)
                    drive(1'b1, 1'b1, x, y, s[0], 1'b0, 3'b000);

        // Random traffic with idle gaps and occasional mid-stream resets
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
                  $urandom_range(0, 1) == 1, 1'b0, 3'b000);
        end

        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 3'b000);
        drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        check("scoreboard_drained", 3'(sb_q.size()), 3'd0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal range 1..32).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  qualifies a, b and is_signed in the current cycle.
REQ-005 a  input  WIDTH  first operand.
REQ-006 b  input  WIDTH  second operand.
REQ-007 is_signed  input  1  1 = two's-complement compare; 0 = unsigned compare.
REQ-008 out_valid  output  1  greater/lesser/equal hold a fresh result.
REQ-009 greater  output  1  registered result a > b.
REQ-010 lesser  output  1  registered result a < b.
REQ-011 equal  output  1  registered result a == b.

Function
REQ-012 Result SHALL be registered with exactly 1-cycle latency: operands sampled at edge N with in_valid=1 appear on the flags and out_valid=1 after edge N.
REQ-013 out_valid SHALL equal in_valid delayed by one cycle; there is no backpressure and no stall.
REQ-014 When in_valid=0 at an edge, greater, lesser and equal SHALL hold their previous values, and out_valid SHALL be 0.
REQ-015 Whenever out_valid=1, exactly one of greater, lesser and equal SHALL be 1 (one-hot).
REQ-016 Unsigned mode SHALL compare a and b as magnitudes 0..2^WIDTH-1.
REQ-017 Signed mode SHALL compare a and b as two's-complement values -2^(WIDTH-1)..2^(WIDTH-1)-1.
REQ-018 equal SHALL be independent of is_signed (bitwise identity).
REQ-019 Back-to-back valid inputs SHALL produce back-to-back results at full throughput of one result per cycle.
REQ-020 Boundary operands (all-zeros, all-ones, MSB-only) SHALL follow REQ-016/017 with no special casing.
REQ-021 No combinational path SHALL exist from any input to any output.

Reset
REQ-022 While rst_n=0 at a rising edge, out_valid, greater and lesser SHALL be cleared to 0 and equal SHALL be cleared to 0.
REQ-023 Reset SHALL take priority over in_valid in the same cycle; an operand pair presented during reset is discarded.
REQ-024 The first result after reset release SHALL come from the first edge with rst_n=1 and in_valid=1.
REQ-025 Asserting reset mid-stream SHALL drop the in-flight result; out_valid SHALL be 0 in the cycle following the reset edge.

Structure
REQ-026 Shared package comparator_pkg SHALL hold the default WIDTH constant and a 3-bit result-flag typedef {greater, equal, lesser}.
REQ-027 One combinational sub-module, comparator_core, SHALL compute the flags from a, b and is_signed.
REQ-028 comparator SHALL wrap comparator_core with the input-qualify and output-register stage.

Verification
REQ-029 Unsigned: a=0110, b=1010, is_signed=0, in_valid=1 -> next cycle lesser=1, greater=0, equal=0, out_valid=1.
REQ-030 Signed: a=0110, b=1010, is_signed=1 -> greater=1, because +6 > -6.
REQ-031 Stream over consecutive cycles, unsigned: (1110,1010) (0100,0010) (0110,0001) (1101,1101) (0111,1010) -> flags G, G, G, E, L on consecutive cycles, out_valid held at 1.
REQ-032 Boundary: unsigned (1111,0000) -> G; signed (1111,0000) -> L; signed (1000,0111) -> L; (0000,0000) -> E in both modes.
REQ-033 Hold and reset: in_valid=0 after a result -> flags unchanged and out_valid=0; rst_n=0 with in_valid=1 -> all outputs 0 on the next cycle, and the first post-reset result is correct.
REQ-034 Every test SHALL check the one-hot property (REQ-015) on each cycle with out_valid=1, and SHALL check all 256 operand pairs in both modes against a reference model.
